// File: rtl/wb_stage.sv
// Writeback stage: selects and aligns load data, registers the register-file write
// and flags misaligned loads, and counts retired instructions.
module wb_stage #(
  parameter int data_width = 32,
  parameter int addr_width = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic                  in_reg_write,
  input  logic [2:0]            in_load_type,
  input  logic [data_width-1:0] in_alu_result,
  input  logic [data_width-1:0] in_mem_rdata,
  input  logic [addr_width-1:0] in_dest_addr,
  output logic                  RegWrite,
  output logic [addr_width-1:0] rd_addr,
  output logic [data_width-1:0] rd_in,
  output logic [3:0]            Rd_byte_w_en,
  output logic                  misalign,
  output logic [31:0]           retired
);

  typedef enum logic [2:0] {
    LT_ALU = 3'b000, LT_LB = 3'b001, LT_LBU = 3'b010, LT_LH  = 3'b011,
    LT_LHU = 3'b100, LT_LW = 3'b101, LT_LWL = 3'b110, LT_LWR = 3'b111
  } load_t;

  load_t                 w_lt;
  logic [1:0]            w_o;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [data_width-1:0] w_data;
  logic [3:0]            w_en;
  logic                  w_mis;
  logic                  w_we;

  logic                  r_we;
  logic [addr_width-1:0] r_addr;
  logic [data_width-1:0] r_data;
  logic [3:0]            r_en;
  logic                  r_mis;
  logic [31:0]           r_retired;

  assign w_lt   = load_t'(in_load_type);
  assign w_o    = in_alu_result[1:0];
  assign w_half = w_o[1] ? in_mem_rdata[31:16] : in_mem_rdata[15:0];

  always_comb begin
    w_byte = in_mem_rdata[7:0];
    case (w_o)
      2'd0: w_byte = in_mem_rdata[7:0];
      2'd1: w_byte = in_mem_rdata[15:8];
      2'd2: w_byte = in_mem_rdata[23:16];
      2'd3: w_byte = in_mem_rdata[31:24];
      default: w_byte = in_mem_rdata[7:0];
    endcase
  end

  always_comb begin
    w_data = in_alu_result;
    w_en   = 4'b1111;
    w_mis  = 1'b0;
    case (w_lt)
      LT_ALU: w_data = in_alu_result;
      LT_LB:  w_data = {{(data_width-8){w_byte[7]}}, w_byte};
      LT_LBU: w_data = {{(data_width-8){1'b0}}, w_byte};
      LT_LH: begin
        w_data = {{(data_width-16){w_half[15]}}, w_half};
        w_mis  = w_o[0];
      end
      LT_LHU: begin
        w_data = {{(data_width-16){1'b0}}, w_half};
        w_mis  = w_o[0];
      end
      LT_LW: begin
        w_data = in_mem_rdata;
        w_mis  = |w_o;
      end
      // Unaligned pair: LWL fills the high bytes, LWR the low bytes; 3-o == ~o
      LT_LWL: begin
        w_data = in_mem_rdata << {~w_o, 3'b000};
        w_en   = 4'b1111 << ~w_o;
      end
      LT_LWR: begin
        w_data = in_mem_rdata >> {w_o, 3'b000};
        w_en   = 4'b1111 >> w_o;
      end
      default: w_data = in_alu_result;
    endcase
    w_mis = w_mis & in_valid;
  end

  assign w_we = in_valid & in_reg_write & (|in_dest_addr) & ~w_mis;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_data    <= '0;
      r_en      <= 4'b0000;
      r_mis     <= 1'b0;
      r_retired <= 32'd0;
    end else if (flush) begin
      r_we   <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
      r_en   <= 4'b0000;
      r_mis  <= 1'b0;
    end else if (!stall) begin
      r_we      <= w_we;
      r_addr    <= in_dest_addr;
      r_data    <= w_data;
      r_en      <= w_we ? w_en : 4'b0000;
      r_mis     <= w_mis;
      r_retired <= r_retired + {31'd0, in_valid};
    end
  end

  assign RegWrite     = r_we;
  assign rd_addr      = r_addr;
  assign rd_in        = r_data;
  assign Rd_byte_w_en = r_en;
  assign misalign     = r_mis;
  assign retired      = r_retired;

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboarded directed bench for wb_stage: the driver queues hand-computed
// expectations, the monitor checks them one edge later.
`timescale 1ns/1ps
module tb_wb_stage;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0, flush = 1'b0, in_valid = 1'b0, in_reg_write = 1'b0;
  logic [2:0]  in_load_type = 3'd0;
  logic [31:0] in_alu_result = '0, in_mem_rdata = '0;
  logic [4:0]  in_dest_addr = '0;
  logic        RegWrite, misalign;
  logic [4:0]  rd_addr;
  logic [31:0] rd_in, retired;
  logic [3:0]  Rd_byte_w_en;

  int tests = 0, fails = 0;

  typedef struct {
    string       name;
    logic        rw;
    logic [4:0]  addr;
    logic [31:0] rd;
    logic [3:0]  en;
    logic        mis;
    logic [31:0] ret;
    logic        chk_data;
  } exp_t;
  exp_t sb[$];

  wb_stage #(.data_width(32), .addr_width(5)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .in_valid(in_valid),
    .in_reg_write(in_reg_write), .in_load_type(in_load_type),
    .in_alu_result(in_alu_result), .in_mem_rdata(in_mem_rdata),
    .in_dest_addr(in_dest_addr), .RegWrite(RegWrite), .rd_addr(rd_addr),
    .rd_in(rd_in), .Rd_byte_w_en(Rd_byte_w_en), .misalign(misalign),
    .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  localparam logic [2:0] ALU = 3'd0, LB = 3'd1, LBU = 3'd2, LH = 3'd3,
                         LHU = 3'd4, LW = 3'd5, LWL = 3'd6, LWR = 3'd7;

  task automatic drive(input string name, input logic st, input logic fl, input logic v,
                       input logic w, input logic [2:0] lt, input logic [31:0] alu,
                       input logic [31:0] mem, input logic [4:0] dst,
                       input logic e_rw, input logic [4:0] e_addr, input logic [31:0] e_rd,
                       input logic [3:0] e_en, input logic e_mis, input logic [31:0] e_ret,
                       input logic e_chk);
    exp_t e;
    @(negedge clk);
    stall = st; flush = fl; in_valid = v; in_reg_write = w; in_load_type = lt;
    in_alu_result = alu; in_mem_rdata = mem; in_dest_addr = dst;
    e.name = name; e.rw = e_rw; e.addr = e_addr; e.rd = e_rd; e.en = e_en;
    e.mis = e_mis; e.ret = e_ret; e.chk_data = e_chk;
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk({e.name, ".RegWrite"}, {31'd0, RegWrite}, {31'd0, e.rw});
        chk({e.name, ".en"}, {28'd0, Rd_byte_w_en}, {28'd0, e.en});
        chk({e.name, ".misalign"}, {31'd0, misalign}, {31'd0, e.mis});
        chk({e.name, ".retired"}, retired, e.ret);
        if (e.chk_data) begin
          chk({e.name, ".rd_addr"}, {27'd0, rd_addr}, {27'd0, e.addr});
          chk({e.name, ".rd_in"}, rd_in, e.rd);
        end
      end
    end
  end

  initial begin : stim
    #1;
    chk("rst.RegWrite", {31'd0, RegWrite}, 32'd0);
    chk("rst.rd_in", rd_in, 32'd0);
    chk("rst.retired", retired, 32'd0);
    #7 rst_n = 1'b1;
    //     name   st fl v w type alu            mem            dst   rw addr rd            en     mis ret chk
    drive("lb3",   0, 0, 1, 1, LB,  32'h1000_0003, 32'h80FF_1234, 5'd8,  1, 8,  32'hFFFF_FF80, 4'hF, 0, 1,  1);
    drive("lbu2",  0, 0, 1, 1, LBU, 32'h1000_0002, 32'h80FF_1234, 5'd9,  1, 9,  32'h0000_00FF, 4'hF, 0, 2,  1);
    drive("lh2",   0, 0, 1, 1, LH,  32'h1000_0002, 32'h80FF_1234, 5'd10, 1, 10, 32'hFFFF_80FF, 4'hF, 0, 3,  1);
    drive("lhu0",  0, 0, 1, 1, LHU, 32'h1000_0000, 32'h80FF_1234, 5'd11, 1, 11, 32'h0000_1234, 4'hF, 0, 4,  1);
    drive("lw0",   0, 0, 1, 1, LW,  32'h1000_0000, 32'hDEAD_BEEF, 5'd12, 1, 12, 32'hDEAD_BEEF, 4'hF, 0, 5,  1);
    drive("lwl1",  0, 0, 1, 1, LWL, 32'h1000_0001, 32'hAABB_CCDD, 5'd13, 1, 13, 32'hCCDD_0000, 4'hC, 0, 6,  1);
    drive("lwr1",  0, 0, 1, 1, LWR, 32'h1000_0001, 32'hAABB_CCDD, 5'd13, 1, 13, 32'h00AA_BBCC, 4'h7, 0, 7,  1);
    drive("lwl0",  0, 0, 1, 1, LWL, 32'h1000_0000, 32'hAABB_CCDD, 5'd14, 1, 14, 32'hDD00_0000, 4'h8, 0, 8,  1);
    drive("lwr3",  0, 0, 1, 1, LWR, 32'h1000_0003, 32'hAABB_CCDD, 5'd14, 1, 14, 32'h0000_00AA, 4'h1, 0, 9,  1);
    drive("lwmis", 0, 0, 1, 1, LW,  32'h1000_0002, 32'hAABB_CCDD, 5'd15, 0, 0,  32'h0,         4'h0, 1, 10, 0);
    drive("alu_r0",0, 0, 1, 1, ALU, 32'h1234_5678, 32'h0,         5'd0,  0, 0,  32'h0,         4'h0, 0, 11, 0);
    drive("lhmis", 0, 0, 1, 1, LH,  32'h1000_0001, 32'h1111_2222, 5'd5,  0, 0,  32'h0,         4'h0, 1, 12, 0);
    drive("alu_o3",0, 0, 1, 1, ALU, 32'h0000_0003, 32'hFFFF_FFFF, 5'd7,  1, 7,  32'h0000_0003, 4'hF, 0, 13, 1);
    drive("stall1",1, 0, 1, 1, LB,  32'h0000_0001, 32'h1234_5678, 5'd1,  1, 7,  32'h0000_0003, 4'hF, 0, 13, 1);
    drive("stall2",1, 0, 1, 1, LW,  32'h0000_0002, 32'h8765_4321, 5'd2,  1, 7,  32'h0000_0003, 4'hF, 0, 13, 1);
    drive("stall3",1, 0, 1, 0, LWR, 32'h0000_0003, 32'h5555_AAAA, 5'd3,  1, 7,  32'h0000_0003, 4'hF, 0, 13, 1);
    drive("stfl",  1, 1, 1, 1, ALU, 32'hFFFF_FFFF, 32'h0,         5'd9,  0, 0,  32'h0,         4'h0, 0, 13, 1);
    drive("alu31", 0, 0, 1, 1, ALU, 32'hCAFE_F00D, 32'h0,         5'd31, 1, 31, 32'hCAFE_F00D, 4'hF, 0, 14, 1);
    drive("flush", 0, 1, 1, 1, LW,  32'h0000_0000, 32'h1234_5678, 5'd6,  0, 0,  32'h0,         4'h0, 0, 14, 1);
    drive("novld", 0, 0, 0, 1, ALU, 32'h0000_0042, 32'h0,         5'd6,  0, 0,  32'h0,         4'h0, 0, 14, 0);
    drive("nowr",  0, 0, 1, 0, LB,  32'h0000_0000, 32'h0000_0011, 5'd3,  0, 0,  32'h0,         4'h0, 0, 15, 0);
    drive("alu9",  0, 0, 1, 1, ALU, 32'h0BAD_F00D, 32'h0,         5'd9,  1, 9,  32'h0BAD_F00D, 4'hF, 0, 16, 1);
    // Asynchronous reset pulse between edges, after the last vector has been checked.
    @(negedge clk);
    in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #0.5;
    chk("arst.RegWrite", {31'd0, RegWrite}, 32'd0);
    chk("arst.rd_addr", {27'd0, rd_addr}, 32'd0);
    chk("arst.rd_in", rd_in, 32'd0);
    chk("arst.en", {28'd0, Rd_byte_w_en}, 32'd0);
    chk("arst.misalign", {31'd0, misalign}, 32'd0);
    chk("arst.retired", retired, 32'd0);
    #0.5 rst_n = 1'b1;
    drive("post",  0, 0, 1, 1, ALU, 32'h0000_0077, 32'h0,         5'd4,  1, 4,  32'h0000_0077, 4'hF, 0, 1,  1);
    drive("idle",  0, 0, 0, 0, ALU, 32'h0,         32'h0,         5'd0,  0, 0,  32'h0,         4'h0, 0, 1,  0);
    repeat (3) @(posedge clk);
    #3;
    chk("sb.drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #20000;
    $display("FAIL watchdog: timeout reached, expected finish before 20000ns");
    $fatal(1);
  end
endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have parameter data_width, default 32, datapath width.
REQ-002 SHALL have parameter addr_width, default 5, register address width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port stall  input  1  hold all WB state.
REQ-006 SHALL have port flush  input  1  discard the incoming instruction.
REQ-007 SHALL have port in_valid  input  1  MEM stage holds a real instruction.
REQ-008 SHALL have port in_reg_write  input  1  instruction writes a register.
REQ-009 SHALL have port in_load_type  input  3  000 ALU, 001 LB, 010 LBU, 011 LH, 100 LHU, 101 LW, 110 LWL, 111 LWR.
REQ-010 SHALL have port in_alu_result  input  data_width  ALU result or effective address.
REQ-011 SHALL have port in_mem_rdata  input  data_width  aligned memory word, little-endian.
REQ-012 SHALL have port in_dest_addr  input  addr_width  destination register.
REQ-013 SHALL have port RegWrite  output  1  register-file write strobe.
REQ-014 SHALL have port rd_addr  output  addr_width  write address.
REQ-015 SHALL have port rd_in  output  data_width  write data.
REQ-016 SHALL have port Rd_byte_w_en  output  4  byte-lane write enables.
REQ-017 SHALL have port misalign  output  1  registered alignment fault.
REQ-018 SHALL have port retired  output  32  count of instructions retired through WB.

Function
REQ-019 SHALL register all outputs; RegWrite, rd_addr, rd_in, Rd_byte_w_en reflect the instruction captured at the previous rising edge (1-cycle latency). The register file writes them on the following falling edge.
REQ-020 SHALL capture inputs each rising edge when stall=0; stall=1 holds every output and the retired count unchanged.
REQ-021 SHALL give flush priority over stall; flush=1 captures a bubble: RegWrite=0, Rd_byte_w_en=0000, misalign=0, rd_addr=0, rd_in=0.
REQ-022 SHALL assert RegWrite only when in_valid=1, in_reg_write=1, in_dest_addr!=0 and no misalignment; otherwise RegWrite=0 and Rd_byte_w_en=0000.
REQ-023 SHALL let o = in_alu_result[1:0] and, for ALU type, set rd_in=in_alu_result, enables 1111.
REQ-024 SHALL, for LB/LBU, set rd_in to byte o of in_mem_rdata, sign- or zero-extended to 32 bits; enables 1111.
REQ-025 SHALL, for LH/LHU, set rd_in to halfword o[1] of in_mem_rdata, sign- or zero-extended; enables 1111; o[0]=1 is misaligned.
REQ-026 SHALL, for LW, set rd_in=in_mem_rdata, enables 1111; o!=0 is misaligned.
REQ-027 SHALL, for LWL, set rd_in = in_mem_rdata shifted left 8*(3-o) bits; enables o=0:1000, 1:1100, 2:1110, 3:1111.
REQ-028 SHALL, for LWR, set rd_in = in_mem_rdata shifted right 8*o bits (zero fill); enables o=0:1111, 1:0111, 2:0011, 3:0001.
REQ-029 SHALL set misalign=1 for exactly one cycle per captured misaligned valid load, suppressing its write.
REQ-030 SHALL increment retired by 1 on each non-stalled, non-flushed edge with in_valid=1, including misaligned and non-writing instructions; wraps FFFFFFFF->00000000.
REQ-031 SHALL ignore in_mem_rdata for ALU type and in_alu_result[1:0] alignment for ALU type.

Reset
REQ-032 SHALL, on rst_n=0, immediately clear RegWrite, rd_addr, rd_in, Rd_byte_w_en, misalign, retired to 0, independent of clk.
REQ-033 SHALL, on reset asserted mid-stream, drop the in-flight instruction with no write; first capture occurs at the first rising edge after rst_n=1.

Verification
REQ-034 SHALL cover: LB, o=3, mem_rdata=80FF1234, dest=8 -> next cycle rd_in=FFFFFF80, enables 1111, RegWrite=1, rd_addr=8.
REQ-035 SHALL cover: LWL o=1 then LWR o=1, mem_rdata=AABBCCDD -> rd_in=CCDD0000/1100, then 00AABBCC/0111.
REQ-036 SHALL cover: LW with alu_result=1000_0002 -> misalign=1 one cycle, RegWrite=0, retired+1.
REQ-037 SHALL cover: stall=1 for 3 cycles with changing inputs -> outputs and retired frozen; stall+flush together -> bubble captured.
REQ-038 SHALL cover: ALU write to dest=0 -> RegWrite=0, retired+1; rst_n pulsed low between clock edges -> all outputs 0 immediately.
